ms_timer: RTL and testbench
===========================

// Module: ms_timer
// PURPOSE
//  Millisecond timer that acts on the reset/up/enable commands from the reaction-time FSM.
//  It returns timer_value to that FSM.
//  - Count-down mode: counts down a pseudo-random wait delay.
//  - Count-up mode: measures the reaction time in ms.
//  It sits between the FSM and the display path, with one instance per reaction-time game.
// PARAMETERS
//  CLKS_PER_MS   50000      clk cycles per millisecond (50 MHz clk); must be >= 2
//  MAX_MS        2047       saturation value of timer_value; must not be a power of two
//  MIN_DELAY_MS  1000       minimum random wait delay (ms)
//  RAND_BITS     10         width of the random part of the delay (0..2**RAND_BITS-1 ms added)
//  LFSR_SEED     16'hACE1   LFSR reset value; must be nonzero
// PORTS
//  clk          in   1                  system clock
//  reset        in   1                  synchronous, active-high global reset
//  clear        in   1                  timer command: load timer (FSM "reset" output)
//  up           in   1                  timer command: 1 = count up, 0 = count down / load random delay
//  enable       in   1                  timer command: 1 = run, 0 = hold
//  timer_value  out  $clog2(MAX_MS)     current count in ms (W = $clog2(MAX_MS))
//  ms_tick      out  1                  one-cycle pulse on each ms boundary while counting
//  at_zero      out  1                  timer_value == 0 (combinational)
//  at_max       out  1                  timer_value == MAX_MS (combinational)
// BEHAVIOUR
//  Reset values
//  - reset=1: timer_value=0, prescaler=0, ms_tick=0, lfsr=LFSR_SEED.
//  - reset has priority over every other input.
//  LFSR
//  - 16-bit Fibonacci LFSR, taps 16,14,13,11.
//  - Advances every clk cycle regardless of clear/enable; never reaches 0.
//  Command priority (evaluated each cycle after reset): clear > enable > hold.
//  clear=1, up=1
//  - timer_value <= 0 on the next edge; prescaler <= 0; ms_tick=0.
//  clear=1, up=0
//  - timer_value <= min(MIN_DELAY_MS + lfsr[RAND_BITS-1:0], MAX_MS); prescaler <= 0; ms_tick=0.
//  - Uses the lfsr value present in the cycle clear is sampled.
//  - clear held high for N cycles reloads each cycle; the last sample wins.
//  enable=1, clear=0
//  - Prescaler counts 0..CLKS_PER_MS-1 and wraps.
//  - In the cycle prescaler==CLKS_PER_MS-1: ms_tick=1 (registered, asserted the following cycle).
//  - timer_value steps on that same edge:
//    - up=1: +1, saturating at MAX_MS; holds at MAX_MS, no wrap.
//    - up=0: -1, sticking at 0; no wrap to MAX_MS.
//  - ms_tick still pulses while saturated or stuck at 0.
//  enable=0, clear=0
//  - timer_value and prescaler hold (pause, not restart); ms_tick=0.
//  Direction changes
//  - A change of up mid-millisecond takes effect at the next tick; the prescaler is not cleared.
//  Latency
//  - From the first enabled cycle after clear, the first step occurs exactly CLKS_PER_MS cycles later.
//  Flags
//  - at_zero and at_max are purely combinational from timer_value.
//  - at_zero=1 out of reset.
//  Mid-operation reset
//  - Mid-count reset returns to the reset values on the next edge; the count is lost.
//  Arithmetic
//  - Loads and steps are computed in W+1 bits and then clamped, so no truncation aliasing occurs.
// TESTING  (bench uses CLKS_PER_MS=4, MAX_MS=2047, MIN_DELAY_MS=1000, RAND_BITS=10)
//  1. reset 2 cycles, then clear=1 up=1 for 1 cycle, then enable=1 up=1 for 40 cycles.
//     -> timer_value=10, exactly 10 ms_tick pulses 4 cycles apart.
//  2. clear=1 up=0 one cycle, with a known LFSR state (reference model).
//     -> timer_value = 1000 + lfsr[9:0], always within 1000..2023.
//  3. enable=1 up=0 from timer_value=2.
//     -> reaches 0 after 8 cycles; at_zero=1 and stays 0 through 20 further cycles of ticks.
//  4. Force count-up from 2045 for 5 ms.
//     -> timer_value=2047 after 2 ms, holds 2047, at_max=1, no wrap to 0.
//  5. enable toggled 0 mid-ms (prescaler=2) for 10 cycles, then 1.
//     -> step occurs 2 enabled cycles later; value unchanged during the pause.
//  6. reset asserted mid-count at timer_value=37, and clear+enable asserted together.
//     -> reset: timer_value=0 next edge; clear+enable: clear wins, no step.

Source files
------------

// File: rtl/ms_timer.sv
// Millisecond timer for the reaction-time game: counts a random wait down, or counts reaction time up.
// Latency: timer_value steps CLKS_PER_MS enabled cycles after a clear; ms_tick is registered (one cycle later).
// Backpressure: none; the FSM commands (clear/up/enable) are obeyed every cycle, clear > enable > hold.
//
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   clear, up, enable timer commands from the game FSM
//   timer_value       current count in ms, W = $clog2(MAX_MS) bits
//   ms_tick           one-cycle pulse on each ms boundary while enabled
//   at_zero, at_max   combinational flags decoded from timer_value
module ms_timer #(
    parameter int          CLKS_PER_MS  = 50000,
    parameter int          MAX_MS       = 2047,
    parameter int          MIN_DELAY_MS = 1000,
    parameter int          RAND_BITS    = 10,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       up,
    input  logic                       enable,
    output logic [$clog2(MAX_MS)-1:0]  timer_value,
    output logic                       ms_tick,
    output logic                       at_zero,
    output logic                       at_max
);

    localparam int W  = $clog2(MAX_MS);
    localparam int PW = $clog2(CLKS_PER_MS);

    // Wide (W+1 bit) constants so loads and increments can exceed MAX_MS before clamping.
    localparam logic [W:0]    MAX_WIDE  = (W+1)'(MAX_MS);
    localparam logic [W:0]    MIN_WIDE  = (W+1)'(MIN_DELAY_MS);
    localparam logic [W-1:0]  MAX_VAL   = W'(MAX_MS);
    localparam logic [PW-1:0] PRESC_END = PW'(CLKS_PER_MS - 1);

    logic [W-1:0]  timer_value_q, timer_value_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          ms_tick_q, ms_tick_d;
    logic [15:0]   lfsr_q, lfsr_d;

    logic          lfsr_fb;
    logic [W:0]    load_wide;
    logic [W:0]    inc_wide;

    // Fibonacci LFSR, polynomial x^16 + x^14 + x^13 + x^11 + 1, right-shifting.
    // A nonzero seed keeps it out of the all-zero lock-up state.
    always_comb begin
        lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
        lfsr_d  = {lfsr_fb, lfsr_q[15:1]};
    end

    always_comb begin
        load_wide = MIN_WIDE + (W+1)'(lfsr_q[RAND_BITS-1:0]);
        inc_wide  = {1'b0, timer_value_q} + (W+1)'(1);
    end

    always_comb begin
        timer_value_d = timer_value_q;
        presc_d       = presc_q;
        ms_tick_d     = 1'b0;

        if (clear) begin
            presc_d = '0;
            if (up) begin
                timer_value_d = '0;
            end else if (load_wide > MAX_WIDE) begin
                timer_value_d = MAX_VAL;
            end else begin
                timer_value_d = load_wide[W-1:0];
            end
        end else if (enable) begin
            if (presc_q == PRESC_END) begin
                presc_d   = '0;
                ms_tick_d = 1'b1;
                // Direction is sampled only at the ms boundary, so a mid-ms change of up
                // simply affects the next step.
                if (up) begin
                    timer_value_d = (inc_wide > MAX_WIDE) ? MAX_VAL : inc_wide[W-1:0];
                end else if (timer_value_q != '0) begin
                    timer_value_d = timer_value_q - W'(1);
                end
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            timer_value_q <= '0;
            presc_q       <= '0;
            ms_tick_q     <= 1'b0;
            lfsr_q        <= LFSR_SEED;
        end else begin
            timer_value_q <= timer_value_d;
            presc_q       <= presc_d;
            ms_tick_q     <= ms_tick_d;
            lfsr_q        <= lfsr_d;
        end
    end

    assign timer_value = timer_value_q;
    assign ms_tick     = ms_tick_q;
    assign at_zero     = (timer_value_q == '0);
    assign at_max      = (timer_value_q == MAX_VAL);

endmodule

// File: tb/tb_ms_timer.sv
// Testbench for ms_timer: directed scenarios plus a random command phase, all checked against a reference model.
// Latency: outputs are sampled 1 time unit after each rising edge.
// Backpressure: not applicable; commands are driven every cycle.
module tb_ms_timer;

    localparam int CLKS = 4;
    localparam int MAXV = 2047;
    localparam int MIND = 1000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clear = 1'b0;
    logic        up = 1'b0;
    logic        enable = 1'b0;
    logic [10:0] timer_value;
    logic        ms_tick;
    logic        at_zero;
    logic        at_max;

    int checks = 0;
    int errors = 0;

    // Reference model state: value in ms, position within the current ms, tick flag, random source.
    int m_val   = 0;
    int m_presc = 0;
    int m_tick  = 0;
    int m_lfsr  = 16'hACE1;

    ms_timer #(
        .CLKS_PER_MS (CLKS),
        .MAX_MS      (MAXV),
        .MIN_DELAY_MS(MIND),
        .RAND_BITS   (10),
        .LFSR_SEED   (16'hACE1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .up         (up),
        .enable     (enable),
        .timer_value(timer_value),
        .ms_tick    (ms_tick),
        .at_zero    (at_zero),
        .at_max     (at_max)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int lfsr_next(input int l);
        int b;
        b = (l ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 1;
        return (l >> 1) | (b << 15);
    endfunction

    // One clock of behaviour, straight from the command rules.
    task automatic model(input logic r, input logic c, input logic u, input logic e);
        if (r) begin
            m_val = 0; m_presc = 0; m_tick = 0; m_lfsr = 16'hACE1;
        end else begin
            m_tick = 0;
            if (c) begin
                m_presc = 0;
                if (u) m_val = 0;
                else   m_val = (MIND + (m_lfsr % 1024) > MAXV) ? MAXV : MIND + (m_lfsr % 1024);
            end else if (e) begin
                if (m_presc == CLKS - 1) begin
                    m_presc = 0;
                    m_tick  = 1;
                    if (u) m_val = (m_val + 1 > MAXV) ? MAXV : m_val + 1;
                    else   m_val = (m_val == 0) ? 0 : m_val - 1;
                end else begin
                    m_presc++;
                end
            end
            m_lfsr = lfsr_next(m_lfsr);
        end
    endtask

    task automatic cyc(input logic r, input logic c, input logic u, input logic e);
        reset = r; clear = c; up = u; enable = e;
        @(posedge clk);
        model(r, c, u, e);
        #1;
        chk("value",   32'(timer_value), 32'(m_val));
        chk("ms_tick", 32'(ms_tick),     32'(m_tick));
        chk("at_zero", 32'(at_zero),     32'(m_val == 0));
        chk("at_max",  32'(at_max),      32'(m_val == MAXV));
    endtask

    initial begin
        int ticks;
        int last_tick;
        int expv;
        int v0;

        // Reset state
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        chk("rst_value", 32'(timer_value), 0);
        chk("rst_tick",  32'(ms_tick), 0);
        chk("rst_zero",  32'(at_zero), 1);

        // 1: count up 40 cycles -> 10 ms, ticks 4 cycles apart
        cyc(0, 1, 1, 0);
        ticks = 0;
        last_tick = -1;
        for (int i = 1; i <= 40; i++) begin
            cyc(0, 0, 1, 1);
            if (ms_tick) begin
                if (last_tick >= 0) chk("t1_spacing", 32'(i - last_tick), 4);
                else                chk("t1_first",   32'(i), 4);
                last_tick = i;
                ticks++;
            end
        end
        chk("t1_value", 32'(timer_value), 10);
        chk("t1_ticks", 32'(ticks), 10);

        // 2: random delay loads use the LFSR state of the sampling cycle
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < int'($urandom_range(7, 0)); j++) cyc(0, 0, 1, 0);
            expv = MIND + (m_lfsr % 1024);
            cyc(0, 1, 0, 0);
            chk("t2_load",  32'(timer_value), 32'(expv));
            chk("t2_range", 32'(timer_value >= 11'd1000 && timer_value <= 11'd2023), 1);
        end

        // 3: count down from 2, stick at 0 while ticks continue
        cyc(0, 1, 1, 0);
        for (int i = 0; i < 8; i++) cyc(0, 0, 1, 1);
        chk("t3_start", 32'(timer_value), 2);
        for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1);
        chk("t3_zero", 32'(timer_value), 0);
        chk("t3_flag", 32'(at_zero), 1);
        ticks = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(0, 0, 0, 1);
            chk("t3_stuck", 32'(at_zero), 1);
            if (ms_tick) ticks++;
        end
        chk("t3_ticks", 32'(ticks), 5);

        // 4: count up to 2045, then saturate at 2047
        cyc(0, 1, 1, 0);
        for (int i = 0; i < 2045 * CLKS; i++) cyc(0, 0, 1, 1);
        chk("t4_2045", 32'(timer_value), 2045);
        for (int i = 0; i < 2 * CLKS; i++) cyc(0, 0, 1, 1);
        chk("t4_sat", 32'(timer_value), 2047);
        chk("t4_max", 32'(at_max), 1);
        for (int i = 0; i < 3 * CLKS; i++) cyc(0, 0, 1, 1);
        chk("t4_hold", 32'(timer_value), 2047);
        chk("t4_nowrap", 32'(at_zero), 0);

        // 5: pause mid-ms with prescaler at 2
        cyc(0, 1, 1, 0);
        cyc(0, 0, 1, 1);
        cyc(0, 0, 1, 1);
        for (int i = 0; i < 10; i++) begin
            cyc(0, 0, 1, 0);
            chk("t5_pause", 32'(timer_value), 0);
        end
        cyc(0, 0, 1, 1);
        chk("t5_before", 32'(timer_value), 0);
        cyc(0, 0, 1, 1);
        chk("t5_step", 32'(timer_value), 1);

        // 6: reset mid-count at 37, then clear+enable together at a ms boundary
        cyc(0, 1, 1, 0);
        for (int i = 0; i < 37 * CLKS; i++) cyc(0, 0, 1, 1);
        chk("t6_37", 32'(timer_value), 37);
        cyc(1, 0, 1, 1);
        chk("t6_reset", 32'(timer_value), 0);
        for (int i = 0; i < 5 * CLKS + 3; i++) cyc(0, 0, 1, 1);
        v0 = int'(timer_value);
        chk("t6_pre", 32'(v0), 5);
        cyc(0, 1, 1, 1);
        chk("t6_clear_wins", 32'(timer_value), 0);
        chk("t6_no_tick", 32'(ms_tick), 0);

        // Random command phase against the model
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(63, 0) == 0), ($urandom_range(15, 0) == 0),
                1'($urandom), ($urandom_range(3, 0) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
